// File: rtl/ms_flood_fill.sv
// ms_flood_fill: flood-fill sequencer for an 8x8 minesweeper board.
// A click seeds one cell. If that cell is a mine, the game is lost. Otherwise
// the open region grows once per cycle using the external neighbour-check
// vector, until it stops growing or MAX_ITER expansion cycles have been used.
//
// Ports
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   start       : single-cycle click request, accepted only in IDLE
//   click_idx   : clicked cell, row = idx/8, column = idx%8
//   clear_board : new game, clears all open state, returns to IDLE
//   is_mine     : mine map, must be stable while busy
//   check       : per cell, "some neighbour is open and zero" (combinational from open)
//   open        : registered open-cell map
//   busy        : high in SEED and EXPAND
//   done        : one-cycle pulse when a click completes without a mine
//   hit_mine    : high while in LOST
//   iter_count  : count of expansion cycles that changed open during the last click
module ms_flood_fill #(
  parameter int unsigned MAX_ITER = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  click_idx,
  input  logic        clear_board,
  input  logic [63:0] is_mine,
  input  logic [63:0] check,
  output logic [63:0] open,
  output logic        busy,
  output logic        done,
  output logic        hit_mine,
  output logic [6:0]  iter_count
);

  typedef enum logic [2:0] {IDLE, SEED, EXPAND, FIN, LOST} state_t;

  localparam logic [6:0] ITER_CAP = 7'(MAX_ITER);

  state_t      state, state_nx;
  logic [5:0]  idx, idx_nx;
  logic [63:0] open_nx, grown;
  logic [6:0]  iter_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      open       <= '0;
      iter_count <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      open       <= open_nx;
      iter_count <= iter_nx;
    end
  end

  always_comb begin
    // Growth is an OR onto open, so bits of open never clear here.
    grown    = open | (check & ~is_mine);
    state_nx = state;
    idx_nx   = idx;
    open_nx  = open;
    iter_nx  = iter_count;

    if (clear_board) begin
      state_nx = IDLE;
      open_nx  = '0;
      iter_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx_nx   = click_idx;
            iter_nx  = '0;
            state_nx = SEED;
          end
        end
        SEED: begin
          if (is_mine[idx]) begin
            open_nx[idx] = 1'b1;
            state_nx     = LOST;
          end else if (open[idx]) begin
            state_nx = FIN;
          end else begin
            open_nx[idx] = 1'b1;
            state_nx     = EXPAND;
          end
        end
        EXPAND: begin
          // A growth cycle that brings the count up to the cap is applied and
          // also ends the click, so at most MAX_ITER growth cycles occur.
          if ((grown != open) && (iter_count < ITER_CAP)) begin
            open_nx = grown;
            iter_nx = iter_count + 7'd1;
            if (iter_count + 7'd1 == ITER_CAP) state_nx = FIN;
          end else begin
            state_nx = FIN;
          end
        end
        FIN:     state_nx = IDLE;
        LOST:    state_nx = LOST;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy     = (state == SEED) || (state == EXPAND);
  assign done     = (state == FIN);
  assign hit_mine = (state == LOST);

endmodule
